// File: rtl/conv_sa_psum_drain_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the psum drain stage.
package conv_sa_psum_drain_pkg;

    localparam int PSUM_W      = 19;
    localparam int DRAIN_OUT_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    // 65-bit FIFO entry: two result words plus the group-last tag
    typedef struct packed {
        logic                   last;
        logic [DRAIN_OUT_W-1:0] data2;
        logic [DRAIN_OUT_W-1:0] data1;
    } drain_entry_t;

    function automatic logic [DRAIN_OUT_W-1:0] zext_psum(input logic [PSUM_W-1:0] p);
        return {{(DRAIN_OUT_W-PSUM_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/conv_sa_drain_fifo.sv
// Synchronous FIFO with a registered first-word (head) output.
// Capacity DEPTH counts the head register plus the backing ring.
// A push on a full FIFO is dropped unless a pop happens in the same cycle.
module conv_sa_drain_fifo
    import conv_sa_psum_drain_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  drain_entry_t             wdata,
    input  logic                     pop_ready,
    output logic                     rd_valid,
    output drain_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    drain_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    mem_cnt;
    logic           head_vld;
    drain_entry_t   head;

    logic pop, full, accept, head_free, mem_empty, to_head, to_mem, from_mem;

    assign count     = mem_cnt + {{AW{1'b0}}, head_vld};
    assign full      = (count == FULL_CNT);
    assign pop       = head_vld && pop_ready;
    assign accept    = push && (!full || pop);
    assign drop      = push && !accept;
    assign head_free = !head_vld || pop;
    assign mem_empty = (mem_cnt == '0);
    // Bypass the ring when the head is (becoming) free and nothing is queued
    assign to_head   = accept && head_free && mem_empty;
    assign to_mem    = accept && !to_head;
    assign from_mem  = head_free && !mem_empty;

    assign rd_valid = head_vld;
    assign rdata    = head;

    // Ring storage write port
    always_ff @(posedge clk) begin
        if (to_mem) mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and head register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mem_cnt  <= '0;
            head_vld <= 1'b0;
            head     <= '0;
        end else begin
            if (to_mem)   wr_ptr <= wr_ptr + AW'(1);
            if (from_mem) rd_ptr <= rd_ptr + AW'(1);
            mem_cnt <= mem_cnt + {{AW{1'b0}}, to_mem} - {{AW{1'b0}}, from_mem};
            if (from_mem) begin
                head     <= mem[rd_ptr];
                head_vld <= 1'b1;
            end else if (to_head) begin
                head     <= wdata;
                head_vld <= 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_sa_psum_drain.sv
// Per-column psum drain: captures flushed psum pairs, adds latched biases,
// buffers results and streams them out. Optional bias path is enabled by
// defining CONV_SA_DRAIN_BIAS_EN; otherwise results are zero-extended psums.
module conv_sa_psum_drain
    import conv_sa_psum_drain_pkg::*;
#(
    parameter int ROWS       = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [PSUM_W-1:0]      in_psum1,
    input  logic [PSUM_W-1:0]      in_psum2,
    input  logic                   in_rst,
    input  logic                   in_flush,
    input  logic [DRAIN_OUT_W-1:0] bias1,
    input  logic [DRAIN_OUT_W-1:0] bias2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DRAIN_OUT_W-1:0] out_data1,
    output logic [DRAIN_OUT_W-1:0] out_data2,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err,
    input  logic                   clr_err
);
    localparam int CW = $clog2(ROWS);
    localparam logic [CW-1:0] CNT_LAST = CW'(ROWS-1);

    drain_state_e   state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           cap, cap_last, proto_err, grp_start;
    logic [DRAIN_OUT_W-1:0] sum1, sum2;
    logic           s_vld;
    drain_entry_t   s_entry, head;
    logic           drop;
    logic [$clog2(FIFO_DEPTH):0] unused_count;

    // Next-state, counter and capture decode; in_rst has priority over in_flush
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        cap_last  = 1'b0;
        proto_err = 1'b0;
        grp_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_rst) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                    grp_start = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (in_rst) begin
                    proto_err = 1'b1;
                    cnt_nxt   = '0;
                    grp_start = 1'b1;
                end else if (in_flush) begin
                    cap = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cap_last  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and group counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef CONV_SA_DRAIN_BIAS_EN
    logic [DRAIN_OUT_W-1:0] bias1_q, bias2_q;

    // Biases are latched at every group start, including an aborted restart
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bias1_q <= '0;
            bias2_q <= '0;
        end else if (grp_start) begin
            bias1_q <= bias1;
            bias2_q <= bias2;
        end
    end

    assign sum1 = bias1_q + zext_psum(in_psum1);
    assign sum2 = bias2_q + zext_psum(in_psum2);
`else
    logic unused_bias;
    assign unused_bias = ^{bias1, bias2, grp_start};
    assign sum1 = zext_psum(in_psum1);
    assign sum2 = zext_psum(in_psum2);
`endif

    // Sum stage: registered at the capture edge, pushed on the following edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_vld   <= 1'b0;
            s_entry <= '0;
        end else begin
            s_vld <= cap;
            if (cap) s_entry <= '{last: cap_last, data2: sum2, data1: sum1};
        end
    end

    conv_sa_drain_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (s_vld),
        .wdata     (s_entry),
        .pop_ready (out_ready),
        .rd_valid  (out_valid),
        .rdata     (head),
        .count     (unused_count),
        .drop      (drop)
    );

    // Sticky error: restart inside a group or an overflow drop; set beats clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  err <= 1'b0;
        else if (proto_err || drop) err <= 1'b1;
        else if (clr_err)           err <= 1'b0;
    end

    assign out_data1 = head.data1;
    assign out_data2 = head.data2;
    assign out_last  = head.last;
    assign busy      = (state == ST_DRAIN);

endmodule
